// File: rtl/pipeline_issue_ctrl.sv
// pipeline_issue_ctrl: credit-limited issue front/back end for a fixed-latency,
// non-stalling pipeline, with an input FIFO for operand pairs and an output FIFO for results.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   in_valid_i/ready_o  - operand pair handshake, with in_op1_i and in_op2_i
//   pipe_op1_o/op2_o    - registered operands driven into the pipeline
//   pipe_res_i          - pipeline result, valid LAT cycles after the operands
//   out_valid_o/ready_i - result handshake, with out_data_o (show-ahead head)
module pipeline_issue_ctrl #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4,
   parameter int RDEPTH = 8,
   parameter int LAT    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DWIDTH-1:0] in_op1_i,
   input  logic [DWIDTH-1:0] in_op2_i,
   output logic [DWIDTH-1:0] pipe_op1_o,
   output logic [DWIDTH-1:0] pipe_op2_o,
   input  logic [DWIDTH-1:0] pipe_res_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DWIDTH-1:0] out_data_o
);

   localparam int IAW = $clog2(DEPTH);
   localparam int RAW = $clog2(RDEPTH);
   localparam int ICW = $clog2(DEPTH + 1);
   localparam int RCW = $clog2(RDEPTH + 1);
   // wide enough for inflight (<= LAT+1) plus rcount (<= RDEPTH)
   localparam int CW  = $clog2(RDEPTH + LAT + 2);

   logic [2*DWIDTH-1:0] r_imem [DEPTH];
   logic [IAW-1:0]      r_iwr;
   logic [IAW-1:0]      r_ird;
   logic [ICW-1:0]      r_icount;

   logic [DWIDTH-1:0]   r_rmem [RDEPTH];
   logic [RAW-1:0]      r_rwr;
   logic [RAW-1:0]      r_rrd;
   logic [RCW-1:0]      r_rcount;

   logic [LAT:0]        r_tag;
   logic [DWIDTH-1:0]   r_op1;
   logic [DWIDTH-1:0]   r_op2;

   logic                w_push;
   logic                w_issue;
   logic                w_wr;
   logic                w_pop;
   logic [CW-1:0]       w_inflight;
   logic [CW-1:0]       w_credit;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i <= LAT; i++) begin
         w_inflight = w_inflight + CW'(r_tag[i]);
      end
   end

   // Every in-flight op plus every held result owns one output slot, so a
   // result arriving from the pipeline always finds room.  A pop in this
   // cycle frees its slot only once rcount has updated.
   assign w_credit    = w_inflight + CW'(r_rcount);
   assign w_issue     = (r_icount != '0) && (w_credit < CW'(RDEPTH));

   assign in_ready_o  = rst && (r_icount != ICW'(DEPTH));
   assign w_push      = in_valid_i && in_ready_o;

   assign w_wr        = r_tag[LAT];
   assign out_valid_o = (r_rcount != '0);
   assign w_pop       = out_valid_o && out_ready_i;
   assign out_data_o  = out_valid_o ? r_rmem[r_rrd] : '0;

   assign pipe_op1_o  = r_op1;
   assign pipe_op2_o  = r_op2;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_imem[r_iwr] <= {in_op1_i, in_op2_i};
      end
      if (w_wr) begin
         r_rmem[r_rwr] <= pipe_res_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_iwr    <= '0;
         r_ird    <= '0;
         r_icount <= '0;
         r_rwr    <= '0;
         r_rrd    <= '0;
         r_rcount <= '0;
         r_tag    <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
      end else begin
         if (w_push) begin
            r_iwr <= r_iwr + IAW'(1);
         end
         if (w_issue) begin
            r_ird <= r_ird + IAW'(1);
            {r_op1, r_op2} <= r_imem[r_ird];
         end else begin
            r_op1 <= '0;
            r_op2 <= '0;
         end
         r_icount <= r_icount + ICW'(w_push) - ICW'(w_issue);

         r_tag <= {r_tag[LAT-1:0], w_issue};

         if (w_wr) begin
            r_rwr <= r_rwr + RAW'(1);
         end
         if (w_pop) begin
            r_rrd <= r_rrd + RAW'(1);
         end
         r_rcount <= r_rcount + RCW'(w_wr) - RCW'(w_pop);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(w_wr && (r_rcount == RCW'(RDEPTH))));

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// tb_pipeline_issue_ctrl: directed and random checks of pipeline_issue_ctrl
// against a result-order queue model and a 3-stage adder/subtractor pipeline.
module tb_pipeline_issue_ctrl;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          out_ready_i = 1'b0;
   logic [DW-1:0] in_op1_i = '0;
   logic [DW-1:0] in_op2_i = '0;
   logic          in_ready_o;
   logic          out_valid_o;
   logic [DW-1:0] pipe_op1_o;
   logic [DW-1:0] pipe_op2_o;
   logic [DW-1:0] pipe_res_i;
   logic [DW-1:0] out_data_o;

   always #5 clk = ~clk;

   // three_stage_pipeline stand-in: res = (op1+op2)-op1, three cycles late
   logic [DW-1:0] s1_sum = '0, s1_a = '0, s2_sum = '0, s2_a = '0, s3 = '0;
   always @(posedge clk) begin
      s1_sum <= pipe_op1_o + pipe_op2_o;
      s1_a   <= pipe_op1_o;
      s2_sum <= s1_sum;
      s2_a   <= s1_a;
      s3     <= s2_sum - s2_a;
   end
   assign pipe_res_i = s3;

   pipeline_issue_ctrl #(
      .DWIDTH(8), .DEPTH(4), .RDEPTH(8), .LAT(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o),
      .in_op1_i(in_op1_i),
      .in_op2_i(in_op2_i),
      .pipe_op1_o(pipe_op1_o),
      .pipe_op2_o(pipe_op2_o),
      .pipe_res_i(pipe_res_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_data_o(out_data_o)
   );

   int            n_assert = 0;
   int            n_fail = 0;
   int            cyc = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   int            got_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: sample both handshakes, update the order model, advance.
   task automatic tick(output logic acc);
      logic popd;
      #1;
      acc  = in_valid_i && in_ready_o;
      popd = out_valid_o && out_ready_i;
      if (popd) begin
         chk("pop_avail", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            chk("pop_data", 32'(out_data_o), 32'(exp_q.pop_front()));
         end
         got_q.push_back(out_data_o);
         got_cyc.push_back(cyc);
      end
      if (acc) exp_q.push_back(in_op2_i);
      if (!rst) exp_q.delete();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      logic a;
      tick(a);
   endtask

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic acc;
      int   n;
      n = 0;
      in_valid_i = 1'b1;
      in_op1_i   = a;
      in_op2_i   = b;
      do begin
         tick(acc);
         n++;
      end while (!acc && n < 200);
      chk("send_accept", 32'(acc), 32'd1);
      in_valid_i = 1'b0;
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      out_ready_i = 1'b1;
      while ((exp_q.size() != 0 || out_valid_o) && n < max) begin
         step();
         n++;
      end
      chk("drain_done", 32'(exp_q.size() == 0 && !out_valid_o), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   k;
      int   n;
      int   n_acc;

      // reset held with a pair offered
      in_valid_i = 1'b1;
      in_op1_i   = 8'h77;
      in_op2_i   = 8'h77;
      for (int i = 0; i < 3; i++) begin
         tick(acc);
         chk("rst_acc", 32'(acc), 32'd0);
         chk("rst_ready", 32'(in_ready_o), 32'd0);
         chk("rst_valid", 32'(out_valid_o), 32'd0);
         chk("rst_op1", 32'(pipe_op1_o), 32'd0);
         chk("rst_op2", 32'(pipe_op2_o), 32'd0);
         chk("rst_data", 32'(out_data_o), 32'd0);
      end
      rst = 1'b1;
      in_valid_i = 1'b0;
      step();
      chk("rel_ready", 32'(in_ready_o), 32'd1);

      // single op latency
      in_valid_i = 1'b1;
      in_op1_i   = 8'h05;
      in_op2_i   = 8'h0A;
      tick(acc);
      chk("one_acc", 32'(acc), 32'd1);
      in_valid_i = 1'b0;
      step();
      chk("one_op1", 32'(pipe_op1_o), 32'h05);
      chk("one_op2", 32'(pipe_op2_o), 32'h0A);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("one_early", 32'(out_valid_o), 32'd0);
      end
      step();
      chk("one_valid", 32'(out_valid_o), 32'd1);
      chk("one_data", 32'(out_data_o), 32'h0A);
      out_ready_i = 1'b1;
      step();
      chk("one_popped", 32'(out_valid_o), 32'd0);
      out_ready_i = 1'b0;

      // wrap arithmetic
      got_q.delete();
      got_cyc.delete();
      out_ready_i = 1'b1;
      send(8'hF0, 8'h20);
      send(8'hFF, 8'hFF);
      send(8'h80, 8'h80);
      drain(50);
      chk("wrap_n", 32'(got_q.size()), 32'd3);
      if (got_q.size() == 3) begin
         chk("wrap_0", 32'(got_q[0]), 32'h20);
         chk("wrap_1", 32'(got_q[1]), 32'hFF);
         chk("wrap_2", 32'(got_q[2]), 32'h80);
      end

      // streaming, one result per cycle
      got_q.delete();
      got_cyc.delete();
      out_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid_i = 1'b1;
         in_op1_i   = DW'($urandom);
         in_op2_i   = DW'(i);
         tick(acc);
         chk("stream_acc", 32'(acc), 32'd1);
      end
      in_valid_i = 1'b0;
      drain(50);
      chk("stream_n", 32'(got_q.size()), 32'd16);
      if (got_q.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            chk("stream_val", 32'(got_q[i]), 32'(i));
            chk("stream_cyc", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
         end
      end

      // full backpressure capacity
      got_q.delete();
      got_cyc.delete();
      out_ready_i = 1'b0;
      k = 0;
      for (int i = 0; i < 40; i++) begin
         in_valid_i = 1'b1;
         in_op1_i   = DW'($urandom);
         in_op2_i   = DW'(8'h40 + k);
         tick(acc);
         if (acc) k++;
      end
      chk("bp_count", 32'(k), 32'd12);
      chk("bp_ready", 32'(in_ready_o), 32'd0);
      chk("bp_valid", 32'(out_valid_o), 32'd1);
      out_ready_i = 1'b1;
      n = 0;
      while (k < 20 && n < 200) begin
         in_valid_i = 1'b1;
         in_op2_i   = DW'(8'h40 + k);
         tick(acc);
         if (acc) k++;
         n++;
      end
      in_valid_i = 1'b0;
      chk("bp_total", 32'(k), 32'd20);
      drain(100);
      chk("bp_n", 32'(got_q.size()), 32'd20);
      if (got_q.size() == 20) begin
         for (int i = 0; i < 20; i++) begin
            chk("bp_order", 32'(got_q[i]), 32'(8'h40 + i));
         end
      end

      // reset with ops in flight and queued
      out_ready_i = 1'b1;
      k = 0;
      while (k < 4) begin
         in_valid_i = 1'b1;
         in_op1_i   = DW'($urandom);
         in_op2_i   = DW'(8'h90 + k);
         tick(acc);
         if (acc) k++;
      end
      rst = 1'b0;
      step();
      rst = 1'b1;
      in_valid_i = 1'b0;
      chk("mid_op1", 32'(pipe_op1_o), 32'd0);
      got_q.delete();
      got_cyc.delete();
      for (int i = 0; i < 10; i++) begin
         step();
         chk("mid_stale", 32'(out_valid_o), 32'd0);
      end
      send(8'h01, 8'h33);
      drain(50);
      chk("mid_n", 32'(got_q.size()), 32'd1);
      if (got_q.size() == 1) chk("mid_val", 32'(got_q[0]), 32'h33);

      // random traffic against the order model
      got_q.delete();
      got_cyc.delete();
      n_acc = 0;
      for (int i = 0; i < 400; i++) begin
         in_valid_i  = 1'($urandom);
         out_ready_i = ($urandom_range(0, 3) != 0);
         in_op1_i    = DW'($urandom);
         in_op2_i    = DW'($urandom);
         tick(acc);
         if (acc) n_acc++;
      end
      in_valid_i = 1'b0;
      drain(200);
      chk("rand_count", 32'(got_q.size()), 32'(n_acc));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
